matrix_op_scheduler: RTL and testbench
======================================

Name: matrix_op_scheduler

Overview:
- Round-robin scheduler that shares one 4x4 element-wise matrix engine among NUM_REQ requesters. The engine is the add/subtract unit with start/done, 8-bit operands and 16-bit results.
- Arbitrates requests and drives the engine's operand-mux select, opcode and start pulse. Waits for engine done, then returns a per-requester ack. A watchdog aborts hung operations.
- Sits between the NPU command front-end and the matrix datapath. Operand and result matrices stay outside this block; it moves control only.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 128, WAIT cycles before abort (≈2 us at 47.25 MHz plus margin).
- CNT_W, 8, width of the saturating timeout counter output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  NUM_REQ  per-requester request level.
- req_op  in  NUM_REQ*2  per-requester opcode, matrix_pkg::op_e, packed with requester i at bits [2i+1:2i].
- ack  out  NUM_REQ  one-cycle completion pulse to the served requester.
- err  out  NUM_REQ  one-cycle pulse coincident with ack when the operation timed out.
- busy  out  1  high in any state other than IDLE.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_op  out  2  opcode to the engine.
- eng_sel  out  $clog2(NUM_REQ)  operand-mux select (index of the served requester).
- eng_done  in  1  engine completion.
- timeout_cnt  out  CNT_W  saturating count of aborted operations.

Behaviour:
- Reset (async, rst_n low): all outputs 0; state IDLE; rr_ptr 0; timer 0; timeout_cnt 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, pick the first high req at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register its index into eng_sel and its opcode into eng_op, then go to ISSUE.
  - With no req high, stay in IDLE.
- ISSUE:
  - eng_start=1 for exactly this cycle; timer cleared; next state is WAIT.
  - eng_done sampled in ISSUE is ignored.
- WAIT:
  - The timer increments each cycle.
  - If eng_done is high, go to DONE with no error.
  - Otherwise, when the timer reaches TIMEOUT_CYC-1, go to DONE with abort flagged.
  - If eng_done is high in the same cycle the timeout fires, eng_done wins: no error.
- DONE:
  - ack[eng_sel]=1 for one cycle; err[eng_sel]=1 if aborted.
  - On abort, timeout_cnt increments, saturating at 2^CNT_W-1.
  - rr_ptr = (eng_sel+1) mod NUM_REQ; next state is IDLE.
- eng_sel and eng_op are held stable from ISSUE through DONE.
- Both keep their last values in IDLE until the next grant.
- Latency:
  - Request seen in IDLE at cycle N → eng_start at N+1.
  - eng_done sampled at cycle D → ack at D+1.
  - Minimum ack-to-next-start gap is 2 cycles (DONE then IDLE).
- Requester rules:
  - Hold req and req_op stable until ack.
  - Drop req on the edge where ack is sampled; a req still high in the following IDLE cycle is a new request.
  - A req dropped before ack does not cancel the operation; ack is still pulsed.
- busy = (state != IDLE).
- Reset mid-operation: the FSM returns to IDLE immediately and eng_start drops. The engine shares rst_n, so no stale done is carried over.

Decomposition:
- matrix_pkg holds:
  - typedef enum logic [1:0] op_e {OP_ADD=0, OP_SUB=1, OP_MULE=2, OP_PASS=3};
  - constants MAT_DIM=4, IN_W=8, OUT_W=16;
  - the sched_state_e enum.
- One sub-module: rr_arbiter. It takes req, rr_ptr and an enable; it outputs grant_valid and a grant_idx combinationally. It is reusable for other shared NPU units.

Test Plan:
- Single op: req=2'b01, req_op[0]=OP_SUB, engine done 4 cycles after start → eng_start at cycle 1, eng_sel=0, eng_op=1, ack=2'b01 at cycle 6, err=0, busy low at cycle 7.
- Fairness: req=2'b11 held, 5-cycle engine, each requester re-requests after ack → grant order 0,1,0,1; no requester is served twice in a row.
- Timeout: TIMEOUT_CYC=16, eng_done tied 0 → ack[0] and err[0] together 17 cycles after eng_start (ISSUE→WAIT→DONE), timeout_cnt=1. Repeated 300 times with CNT_W=8 → timeout_cnt saturates at 255.
- Spurious done: eng_done pulsed during ISSUE, then real done 3 cycles later → no early ack; ack one cycle after the real done.
- Tie: eng_done asserted on the timer's final WAIT cycle → ack with err=0; timeout_cnt unchanged.
- Reset mid-WAIT: rst_n low for 2 cycles during WAIT of requester 1 → all outputs 0 asynchronously. After release with req=2'b11, requester 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared opcode, geometry and scheduler-state types for the matrix engine
// Exports op_e (engine opcodes), MAT_DIM/IN_W/OUT_W geometry, and sched_state_e.
package matrix_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MULE = 2'd2, OP_PASS = 2'd3} op_e;
  localparam int MAT_DIM = 4;
  localparam int IN_W = 8;
  localparam int OUT_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after a pointer
// Ports: i_req request vector, i_ptr priority start index, i_en enable,
//        o_grant_valid any request granted, o_grant_idx granted index.
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic          o_grant_valid,
  output logic [IW-1:0] o_grant_idx
);
  assign o_grant_valid = i_en & |i_req;
  // Scan offsets from farthest to nearest so the nearest requester at or after i_ptr wins.
  always_comb begin
    o_grant_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (i_req[(int'(i_ptr) + k) % N]) o_grant_idx = IW'((int'(i_ptr) + k) % N);
  end
endmodule

// File: rtl/matrix_op_scheduler.sv
// matrix_op_scheduler: round-robin sharing of one matrix engine with start/done handshake and watchdog
// Ports: req/req_op requester levels and opcodes, ack/err completion pulses, busy,
//        eng_start/eng_op/eng_sel engine control, eng_done engine completion,
//        timeout_cnt saturating count of aborted operations.
module matrix_op_scheduler
  import matrix_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYC = 128,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       req_op,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic                       eng_start,
  output logic [1:0]                 eng_op,
  output logic [$clog2(NUM_REQ)-1:0] eng_sel,
  input  logic                       eng_done,
  output logic [CNT_W-1:0]           timeout_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  sched_state_e r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [TW-1:0] r_timer;
  logic w_grant_valid;
  logic [IW-1:0] w_grant_idx;
  logic [NUM_REQ-1:0] w_sel_oh;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req(req),
    .i_ptr(r_rr_ptr),
    .i_en(r_state == S_IDLE),
    .o_grant_valid(w_grant_valid),
    .o_grant_idx(w_grant_idx)
  );
  assign w_sel_oh = NUM_REQ'(1) << eng_sel;
  assign busy = r_state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr_ptr <= '0;
      r_timer <= '0;
      ack <= '0;
      err <= '0;
      eng_start <= 1'b0;
      eng_op <= '0;
      eng_sel <= '0;
      timeout_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant_valid) begin
          eng_sel <= w_grant_idx;
          eng_op <= req_op[{w_grant_idx, 1'b0} +: 2];
          eng_start <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          eng_start <= 1'b0;
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A done arriving on the final watchdog cycle still counts as a clean completion.
          if (eng_done || r_timer == TW'(TIMEOUT_CYC - 1)) begin
            ack <= w_sel_oh;
            err <= eng_done ? '0 : w_sel_oh;
            if (!eng_done && !(&timeout_cnt)) timeout_cnt <= timeout_cnt + 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          ack <= '0;
          err <= '0;
          r_rr_ptr <= (int'(eng_sel) == NUM_REQ - 1) ? '0 : eng_sel + 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_op_scheduler.sv
// tb_matrix_op_scheduler: randomized and directed checks of the scheduler against a transaction-level model
module tb_matrix_op_scheduler;
  localparam int N = 3;
  localparam int T = 16;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] req_op = '0;
  logic [N-1:0] ack, err;
  logic busy, eng_start, eng_done = 1'b0;
  logic [1:0] eng_op;
  logic [$clog2(N)-1:0] eng_sel;
  logic [CW-1:0] timeout_cnt;
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  int mcnt = 0;
  int got, prev;
  always #5 clk = ~clk;
  matrix_op_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .ack(ack), .err(err),
    .busy(busy), .eng_start(eng_start), .eng_op(eng_op), .eng_sel(eng_sel),
    .eng_done(eng_done), .timeout_cnt(timeout_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // One complete transaction: done asserted d cycles after eng_start (d outside 1..T means never).
  task automatic run_txn(input logic [N-1:0] r, input logic [2*N-1:0] ops, input int d,
                         input bit spur, output int g);
    int idx, n, exp_n;
    bit ab;
    logic [N-1:0] oh;
    idx = pick(r, mptr);
    oh = '0;
    oh[idx] = 1'b1;
    req = r;
    req_op = ops;
    step();
    chk("start", eng_start, 1);
    chk("sel", eng_sel, idx);
    chk("op", eng_op, ops[2*idx +: 2]);
    chk("busy", busy, 1);
    g = int'(eng_sel);
    eng_done = spur;
    ab = !(d >= 1 && d <= T);
    exp_n = ab ? T + 1 : d + 1;
    n = 0;
    while (ack == '0 && n < T + 5) begin
      step();
      n++;
      if (n == 1) chk("start_drop", eng_start, 0);
      eng_done = (n == d);
    end
    chk("ack_lat", n, exp_n);
    chk("ack", ack, oh);
    chk("err", err, ab ? oh : '0);
    chk("hold_sel", eng_sel, idx);
    chk("hold_op", eng_op, ops[2*idx +: 2]);
    if (ab && mcnt < 255) mcnt++;
    chk("tcnt", timeout_cnt, mcnt);
    req = '0;
    eng_done = 1'b0;
    step();
    chk("idle_busy", busy, 0);
    chk("ack_clr", ack, 0);
    chk("err_clr", err, 0);
    mptr = (idx + 1) % N;
  endtask
  initial begin
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_sel", eng_sel, 0);
    chk("rst_op", eng_op, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_nostart", eng_start, 0);
    run_txn(3'b001, 6'b00_00_01, 4, 1'b0, got);
    chk("single_idx", got, 0);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run_txn(3'b011, 6'b00_10_11, 5, 1'b0, got);
      chk("fair_alt", got != prev, 1);
      prev = got;
    end
    run_txn(3'b001, 6'b00_00_00, -1, 1'b0, got);
    chk("timeout_cnt1", timeout_cnt, 1);
    run_txn(3'b100, 6'b11_00_00, 3, 1'b1, got);
    run_txn(3'b010, 6'b00_01_00, T, 1'b0, got);
    chk("tie_cnt", timeout_cnt, 1);
    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] r;
      int d;
      r = N'($urandom_range(1, (1 << N) - 1));
      d = $urandom_range(1, T + 2);
      run_txn(r, 6'($urandom), d, $urandom_range(0, 3) == 0, got);
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("gap_start", eng_start, 0);
        chk("gap_busy", busy, 0);
      end
    end
    req = 3'b010;
    step();
    chk("mid_start", eng_start, 1);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", ack, 0);
    chk("arst_err", err, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", eng_start, 0);
    chk("arst_sel", eng_sel, 0);
    chk("arst_op", eng_op, 0);
    chk("arst_tcnt", timeout_cnt, 0);
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    mptr = 0;
    mcnt = 0;
    run_txn(3'b011, 6'b00_01_10, 2, 1'b0, got);
    chk("post_rst_first", got, 0);
    for (int i = 0; i < 300; i++) run_txn(3'b111, 6'b00_00_00, -1, 1'b0, got);
    chk("tcnt_sat", timeout_cnt, 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
